// File: rtl/if_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_stage_pkg
//   Shared definitions for the fetch / decode boundary:
//     - datapath width (DSIZE) and register-address width (ASIZE)
//     - instruction field positions (op, rd, rs, rt)
//     - NOP encoding loaded into IF/ID on a redirect
//     - the IF/ID register record and the PC-update selector
//     - small field-extraction helpers used by the hazard logic
// -----------------------------------------------------------------------------
package if_id_stage_pkg;

  // Machine word and register-file address widths.
  localparam int DSIZE = 16;
  localparam int ASIZE = 4;

  // Instruction layout: op is the top nibble, then rd, rs, rt in descending
  // ASIZE-wide slices. For 16/4 this gives op[15:12] rd[11:8] rs[7:4] rt[3:0].
  localparam int OP_W   = 4;
  localparam int OP_MSB = DSIZE - 1;
  localparam int OP_LSB = DSIZE - OP_W;
  localparam int RD_MSB = OP_LSB - 1;
  localparam int RD_LSB = OP_LSB - ASIZE;
  localparam int RS_MSB = RD_LSB - 1;
  localparam int RS_LSB = RD_LSB - ASIZE;
  localparam int RT_MSB = RS_LSB - 1;
  localparam int RT_LSB = RS_LSB - ASIZE;

  typedef logic [DSIZE-1:0] word_t;
  typedef logic [ASIZE-1:0] reg_addr_t;

  // All-zero word is the architectural NOP.
  localparam word_t NOP = '0;

  // Register zero is hard-wired; a load targeting it never creates a hazard.
  localparam reg_addr_t REG_ZERO = '0;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    word_t instr;
    word_t nextpc;
    logic  valid;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{instr: NOP, nextpc: '0, valid: 1'b0};

  // What the fetch stage does on the coming clock edge.
  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,  // advance PC, capture fetched word
    PC_HOLD     = 2'd1,  // load-use stall: freeze PC and IF/ID
    PC_REDIRECT = 2'd2   // taken branch: jump and squash IF/ID
  } pc_sel_e;

  function automatic reg_addr_t rs_field(input word_t instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic reg_addr_t rt_field(input word_t instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage : if_id_stage_pkg

// File: rtl/if_id_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use detector. Flags a hazard when the
//   instruction sitting in IF/ID reads (rs or rt) the register that the load
//   currently in ID/EXE will write. Register zero never hazards, and an empty
//   IF/ID slot (valid=0) never hazards.
//
// Ports
//   valid        in   IF/ID holds a real instruction
//   instr        in   IF/ID instruction word
//   ex_mem_read  in   ID/EXE instruction is a load
//   ex_waddr     in   destination register of that load
//   hazard       out  stall fetch and decode this cycle
// -----------------------------------------------------------------------------
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic      valid,
  input  word_t     instr,
  input  logic      ex_mem_read,
  input  reg_addr_t ex_waddr,
  output logic      hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_waddr == rs_field(instr));
  assign rt_match = (ex_waddr == rt_field(instr));

  assign hazard = valid
               && ex_mem_read
               && (ex_waddr != REG_ZERO)
               && (rs_match || rt_match);

endmodule : hazard_detect

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Instruction fetch plus the IF/ID pipeline register.
//     - PC register drives the instruction memory address combinationally;
//       memory returns the word in the same cycle.
//     - Normal cycle: PC <= PC+1, IF/ID <= {word, PC+1, valid}.
//     - Load-use hazard: PC and IF/ID freeze, decode inserts a bubble.
//     - Taken branch: PC <= target, IF/ID <= NOP (invalid), bubble.
//       A branch wins over a simultaneous hazard.
//     - Saturating counters record stall and flush events.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   branch_taken_in     redirect from execute
//   branch_target_in    redirect PC
//   ex_mem_read_in      ID/EXE instruction is a load
//   ex_waddr_in         its destination register
//   imem_data_in        instruction word at imem_addr_out
//   imem_addr_out       current PC
//   nextpc_out          PC+1 of the instruction in IF/ID
//   instr_out           instruction for decode
//   valid_out           instr_out is a real instruction
//   bubble_out          decode must drive zero controls into ID/EXE
//   stall_cnt_out       saturating load-use stall count
//   flush_cnt_out       saturating branch flush count
// -----------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken_in,
  input  logic [DSIZE-1:0] branch_target_in,
  input  logic             ex_mem_read_in,
  input  logic [ASIZE-1:0] ex_waddr_in,
  input  logic [DSIZE-1:0] imem_data_in,
  output logic [DSIZE-1:0] imem_addr_out,
  output logic [DSIZE-1:0] nextpc_out,
  output logic [DSIZE-1:0] instr_out,
  output logic             valid_out,
  output logic             bubble_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  word_t            pc;
  word_t            pc_plus1;
  if_id_t           if_id;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hazard;
  pc_sel_e          pc_sel;

  // ---------------------------------------------------------------------------
  // Hazard detection on the instruction currently held in IF/ID.
  // ---------------------------------------------------------------------------
  hazard_detect u_hazard_detect (
    .valid       (if_id.valid),
    .instr       (if_id.instr),
    .ex_mem_read (ex_mem_read_in),
    .ex_waddr    (ex_waddr_in),
    .hazard      (hazard)
  );

  // Word-addressed increment; wraps naturally at 2^DSIZE.
  assign pc_plus1 = pc + DSIZE'(1);

  // ---------------------------------------------------------------------------
  // Next-action select. Redirect outranks the stall: the stalled instruction
  // is on the wrong path anyway and gets squashed.
  // ---------------------------------------------------------------------------
  // NOTE: pc_sel gets a default before any branch of the if chain, so the
  // block is combinational on every path and no latch is inferred.
  always_comb begin
    pc_sel = PC_SEQ;
    if (branch_taken_in) begin
      pc_sel = PC_REDIRECT;
    end else if (hazard) begin
      pc_sel = PC_HOLD;
    end
  end

  // Any non-sequential cycle leaves nothing useful for decode to issue.
  // hazard is already gated by valid, so an empty slot never bubbles
  // unless a redirect is in progress.
  assign bubble_out = (pc_sel != PC_SEQ);

  // ---------------------------------------------------------------------------
  // PC and IF/ID register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order. Reset is
  // synchronous: it is just the highest-priority term inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      if_id <= IF_ID_EMPTY;
    end else begin
      unique case (pc_sel)
        PC_REDIRECT: begin
          pc    <= branch_target_in;
          if_id <= IF_ID_EMPTY;
        end
        PC_HOLD: begin
          pc    <= pc;
          if_id <= if_id;
        end
        default: begin
          pc    <= pc_plus1;
          if_id <= '{instr: imem_data_in, nextpc: pc_plus1, valid: 1'b1};
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_sel == PC_HOLD && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (pc_sel == PC_REDIRECT && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr_out = pc;
  assign nextpc_out    = if_id.nextpc;
  assign instr_out     = if_id.instr;
  assign valid_out     = if_id.valid;
  assign stall_cnt_out = stall_cnt;
  assign flush_cnt_out = flush_cnt;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//   Directed table of cycles with hand-derived expectations, a long stall run
//   for counter saturation (second instance with CNT_W=4), then randomized
//   traffic compared against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      branch_taken_in = 1'b0;
  word_t     branch_target_in = '0;
  logic      ex_mem_read_in = 1'b0;
  reg_addr_t ex_waddr_in = '0;
  word_t     imem_data_in;
  logic      mem_mode = 1'b0;

  word_t       imem_addr_out, nextpc_out, instr_out;
  logic        valid_out, bubble_out;
  logic [15:0] stall_cnt_out, flush_cnt_out;

  word_t       addr4, np4, instr4;
  logic        valid4, bubble4;
  logic [3:0]  stall4, flush4;

  always #5 clk = ~clk;

  // Instruction memory: mode 0 returns 0x1000+addr, mode 1 a scrambled word.
  function automatic word_t mem_at(input logic mode, input word_t a);
    if (mode) return word_t'(a * 16'h9E37 + 16'h5A5A);
    return word_t'(a + 16'h1000);
  endfunction

  assign imem_data_in = mem_mode ? word_t'(imem_addr_out * 16'h9E37 + 16'h5A5A)
                                 : word_t'(imem_addr_out + 16'h1000);

  if_id_stage dut (
    .clk(clk), .rst(rst),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .ex_mem_read_in(ex_mem_read_in), .ex_waddr_in(ex_waddr_in),
    .imem_data_in(imem_data_in), .imem_addr_out(imem_addr_out),
    .nextpc_out(nextpc_out), .instr_out(instr_out), .valid_out(valid_out),
    .bubble_out(bubble_out), .stall_cnt_out(stall_cnt_out),
    .flush_cnt_out(flush_cnt_out)
  );

  // Narrow-counter instance, same stimulus; the memory follows dut's PC,
  // which is identical since both see the same inputs.
  if_id_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .ex_mem_read_in(ex_mem_read_in), .ex_waddr_in(ex_waddr_in),
    .imem_data_in(imem_data_in), .imem_addr_out(addr4),
    .nextpc_out(np4), .instr_out(instr4), .valid_out(valid4),
    .bubble_out(bubble4), .stall_cnt_out(stall4), .flush_cnt_out(flush4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, away from the rising edge.
  task automatic drive(input logic r, input logic b, input word_t t,
                       input logic m, input reg_addr_t w);
    @(negedge clk);
    rst = r; branch_taken_in = b; branch_target_in = t;
    ex_mem_read_in = m; ex_waddr_in = w;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic      rst, br;
    word_t     tgt;
    logic      mr;
    reg_addr_t wa;
    logic      chk_bub, bub;   // combinational bubble before the edge
    word_t     pc, instr, np;  // state after the edge
    logic      valid;
    int        stall, flush;
  } vec_t;

  function automatic vec_t v(input logic r, b, input word_t t, input logic m,
                             input reg_addr_t w, input logic cb, bb,
                             input word_t pc, ins, np, input logic vl,
                             input int st, fl);
    vec_t x;
    x.rst = r; x.br = b; x.tgt = t; x.mr = m; x.wa = w;
    x.chk_bub = cb; x.bub = bb;
    x.pc = pc; x.instr = ins; x.np = np; x.valid = vl;
    x.stall = st; x.flush = fl;
    return x;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Behavioural model state.
  word_t m_pc, m_instr, m_np;
  logic  m_valid;
  int    m_stall, m_flush;

  vec_t tbl[$];

  initial begin
    // ---------------------------------------------------------------- table
    //             rst br tgt      mr wa    cb bub  pc       instr    np       vl st fl
    tbl.push_back(v(1, 0, 16'h0,    0, 4'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h0, 1, 0, 16'h0001, 16'h1000, 16'h0001, 1, 0, 0));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h0, 1, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 0));
    tbl.push_back(v(0, 1, 16'h1034, 0, 4'h0, 1, 1, 16'h1034, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h0, 1, 0, 16'h1035, 16'h2034, 16'h1035, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0,    1, 4'h3, 1, 1, 16'h1035, 16'h2034, 16'h1035, 1, 1, 1));
    tbl.push_back(v(0, 0, 16'h0,    1, 4'h0, 1, 0, 16'h1036, 16'h2035, 16'h1036, 1, 1, 1));
    tbl.push_back(v(0, 0, 16'h0,    1, 4'h5, 1, 1, 16'h1036, 16'h2035, 16'h1036, 1, 2, 1));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h5, 1, 0, 16'h1037, 16'h2036, 16'h1037, 1, 2, 1));
    tbl.push_back(v(0, 1, 16'h0040, 0, 4'h0, 1, 1, 16'h0040, 16'h0000, 16'h0000, 0, 2, 2));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h0, 1, 0, 16'h0041, 16'h1040, 16'h0041, 1, 2, 2));
    tbl.push_back(v(0, 1, 16'h1034, 1, 4'h4, 1, 1, 16'h1034, 16'h0000, 16'h0000, 0, 2, 3));
    tbl.push_back(v(0, 0, 16'h0,    1, 4'h4, 1, 0, 16'h1035, 16'h2034, 16'h1035, 1, 2, 3));
    tbl.push_back(v(0, 1, 16'hFFFF, 0, 4'h0, 1, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 2, 4));
    tbl.push_back(v(0, 0, 16'h0,    0, 4'h0, 1, 0, 16'h0000, 16'h0FFF, 16'h0000, 1, 2, 4));
    tbl.push_back(v(1, 0, 16'h0,    1, 4'hF, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h0,    1, 4'hF, 1, 0, 16'h0001, 16'h1000, 16'h0001, 1, 0, 0));

    mem_mode = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].br, tbl[i].tgt, tbl[i].mr, tbl[i].wa);
      if (tbl[i].chk_bub) check($sformatf("tbl%0d bubble", i), bubble_out, tbl[i].bub);
      after_edge();
      check($sformatf("tbl%0d pc", i),     imem_addr_out, tbl[i].pc);
      check($sformatf("tbl%0d instr", i),  instr_out,     tbl[i].instr);
      check($sformatf("tbl%0d nextpc", i), nextpc_out,    tbl[i].np);
      check($sformatf("tbl%0d valid", i),  valid_out,     tbl[i].valid);
      check($sformatf("tbl%0d stall", i),  stall_cnt_out, tbl[i].stall);
      check($sformatf("tbl%0d flush", i),  flush_cnt_out, tbl[i].flush);
      check($sformatf("tbl%0d stall4", i), stall4,        sat(tbl[i].stall, 4));
    end

    // ------------------------------------------------- counter saturation
    drive(0, 1, 16'h1034, 0, 4'h0);
    after_edge();
    drive(0, 0, 16'h0, 0, 4'h0);
    after_edge();
    check("sat setup instr", instr_out, 16'h2034);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 16'h0, 1, 4'h3);
      after_edge();
    end
    check("sat pc held",  imem_addr_out, 16'h1035);
    check("sat instr",    instr_out,     16'h2034);
    check("sat stall16",  stall_cnt_out, 20);
    check("sat stall4",   stall4,        15);
    check("sat flush4",   flush4,        1);
    drive(0, 0, 16'h0, 0, 4'h0);
    after_edge();
    check("sat release pc", imem_addr_out, 16'h1036);
    check("sat stall4 hold", stall4, 15);

    // ----------------------------------------------------- random traffic
    mem_mode = 1'b1;
    drive(1, 0, 16'h0, 0, 4'h0);
    after_edge();
    m_pc = '0; m_instr = '0; m_np = '0; m_valid = 1'b0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      logic      r, b, m, hz, exp_bub;
      word_t     t;
      reg_addr_t w;
      r = ($urandom_range(0, 63) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = word_t'($urandom);
      m = $urandom_range(0, 1);
      // Bias the load destination toward the current operands so stalls occur.
      case ($urandom_range(0, 3))
        0: w = m_instr[7:4];
        1: w = m_instr[3:0];
        default: w = reg_addr_t'($urandom);
      endcase
      drive(r, b, t, m, w);

      hz = m_valid && m && (w != 0) && (w == m_instr[7:4] || w == m_instr[3:0]);
      exp_bub = b || hz;
      check("rnd bubble", bubble_out, exp_bub);
      check("rnd addr", imem_addr_out, m_pc);

      if (r) begin
        m_pc = '0; m_instr = '0; m_np = '0; m_valid = 0; m_stall = 0; m_flush = 0;
      end else if (b) begin
        m_pc = t; m_instr = NOP; m_np = '0; m_valid = 0; m_flush++;
      end else if (hz) begin
        m_stall++;
      end else begin
        m_instr = mem_at(1'b1, m_pc);
        m_pc    = m_pc + 16'd1;
        m_np    = m_pc;
        m_valid = 1'b1;
      end

      after_edge();
      check("rnd pc",     imem_addr_out, m_pc);
      check("rnd instr",  instr_out,     m_instr);
      check("rnd nextpc", nextpc_out,    m_np);
      check("rnd valid",  valid_out,     m_valid);
      check("rnd stall",  stall_cnt_out, sat(m_stall, 16));
      check("rnd flush",  flush_cnt_out, sat(m_flush, 16));
      check("rnd stall4", stall4,        sat(m_stall, 4));
      check("rnd flush4", flush4,        sat(m_flush, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_id_stage

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: branch_taken_in  input  1  redirect request from the execute stage.
REQ-005 SHALL have port: branch_target_in  input  DSIZE  redirect PC.
REQ-006 SHALL have port: ex_mem_read_in  input  1  the instruction now in the ID/EXE register is a load.
REQ-007 SHALL have port: ex_waddr_in  input  ASIZE  destination register of that load.
REQ-008 SHALL have port: imem_data_in  input  DSIZE  instruction word at imem_addr_out, valid in the same cycle.
REQ-009 SHALL have port: imem_addr_out  output  DSIZE  current PC, combinational from the PC register.
REQ-010 SHALL have port: nextpc_out  output  DSIZE  registered PC+1 of the instruction held in IF/ID.
REQ-011 SHALL have port: instr_out  output  DSIZE  registered instruction for decode.
REQ-012 SHALL have port: valid_out  output  1  instr_out holds a real instruction.
REQ-013 SHALL have port: bubble_out  output  1  combinational; decode drives zero controls into ID/EXE this cycle.
REQ-014 SHALL have ports: stall_cnt_out and flush_cnt_out, both output, CNT_W wide, saturating event counters.

Function
REQ-015 SHALL use word-addressed PC arithmetic: PC+1 computed modulo 2^DSIZE, so 0xFFFF wraps to 0x0000 for DSIZE=16.
REQ-016 SHALL decode instruction fields as op[DSIZE-1:DSIZE-4], rd, rs, rt in descending ASIZE-wide slices below op (for 16/4: rd[11:8], rs[7:4], rt[3:0]).
REQ-017 SHALL flag a load-use hazard when valid_out=1, ex_mem_read_in=1, ex_waddr_in!=0, and ex_waddr_in equals the rs or rt field of instr_out.
REQ-018 SHALL, on hazard with no branch: hold PC, hold IF/ID contents, assert bubble_out, and increment stall_cnt_out.
REQ-019 SHALL, on branch_taken_in=1: load PC with branch_target_in, load IF/ID with instr_out=0 (NOP), valid_out=0, nextpc_out=0, assert bubble_out, and increment flush_cnt_out.
REQ-020 SHALL give branch priority over hazard when both occur in one cycle; stall_cnt_out does not increment.
REQ-021 SHALL, in a normal cycle, load PC with PC+1 and load IF/ID with instr_out=imem_data_in, nextpc_out=PC+1, valid_out=1, with bubble_out=0.
REQ-022 SHALL add one cycle of fetch-to-decode latency: the word fetched at PC appears on instr_out in the next cycle.
REQ-023 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-024 SHALL keep bubble_out free of hazard assertion while valid_out=0.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, clear PC, nextpc_out, instr_out, valid_out, stall_cnt_out and flush_cnt_out to 0, overriding any branch or stall in that cycle.
REQ-026 SHALL fetch from address 0 in the first cycle after rst deasserts.
REQ-027 SHALL drive bubble_out=0 while valid_out=0 after reset.

Structure
REQ-028 SHALL take DSIZE and ASIZE from the shared define file, and SHALL place the field-position constants and the NOP encoding (0) in that shared file.
REQ-029 SHALL contain one sub-module, hazard_detect, that is combinational and implements REQ-017; PC, IF/ID and the counters stay in if_id_stage.

Verification
REQ-030 SHALL cover reset release with imem returning 0x1000+addr -> imem_addr_out 0,1,2; instr_out 0x1000,0x1001 one cycle later; valid_out=1 from the second edge.
REQ-031 SHALL cover load-use: instr_out=0x2034 (rs=3, rt=4), ex_mem_read_in=1, ex_waddr_in=3 -> bubble_out=1, PC and instr_out hold one cycle, stall_cnt_out=1; with ex_waddr_in=0 -> no stall.
REQ-032 SHALL cover a taken branch to 0x0040 -> next imem_addr_out=0x0040, instr_out=0, valid_out=0, flush_cnt_out=1; the following cycle instr_out=word at 0x0040.
REQ-033 SHALL cover simultaneous hazard and branch -> branch taken, PC=target, stall_cnt_out unchanged, flush_cnt_out+1.
REQ-034 SHALL cover wrap and saturation: PC forced to 0xFFFF -> next PC 0x0000; CNT_W=4 with 20 stalls -> stall_cnt_out=15.
REQ-035 SHALL cover reset mid-stall: rst asserted during an active hazard -> all outputs 0 next cycle and fetch restarts at 0.
